// File: rtl/ps2_move_scheduler.sv
// Turns held PS/2 direction levels into maze moves with typematic auto-repeat,
// newest-press arbitration and a one-entry skid slot on the valid/ready output.
//
// state  | meaning
// IDLE   | no active direction, waiting for a fresh press
// DELAY  | active key held, counting to the first auto-repeat
// REPEAT | active key held, issuing periodic auto-repeats
module ps2_move_scheduler #(
    parameter int DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       enter,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       select,
    output logic       key_held
);
    localparam int MAX_CYCLES = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES);
    localparam logic [TW-1:0] DELAY_TC  = TW'(DELAY_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_TC = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    active;
    logic [3:0]    dir_prev;
    logic          enter_prev;
    logic          armed;
    logic          skid_valid;
    logic [1:0]    skid_dir;

    logic [3:0] dir_lvl;
    logic [3:0] dir_rise;
    logic       enter_rise;
    logic       press;
    logic       any_held;
    logic       active_lost;
    logic [1:0] press_dir;
    logic [1:0] held_dir;

    // Lowest bit index wins, which gives up > down > left > right.
    function automatic logic [1:0] first_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // armed masks the first cycle after reset so keys held through reset stay silent.
    assign dir_lvl     = {right, left, down, up};
    assign dir_rise    = dir_lvl & ~dir_prev & {4{armed}};
    assign enter_rise  = enter & ~enter_prev & armed;
    assign press       = |dir_rise;
    assign any_held    = |dir_lvl;
    assign press_dir   = first_set(dir_rise);
    assign held_dir    = first_set(dir_lvl);
    assign active_lost = (state != IDLE) && !dir_lvl[active];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            active     <= 2'd0;
            dir_prev   <= 4'd0;
            enter_prev <= 1'b0;
            armed      <= 1'b0;
            skid_valid <= 1'b0;
            skid_dir   <= 2'd0;
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            select     <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            dir_prev   <= dir_lvl;
            enter_prev <= enter;
            armed      <= 1'b1;
            select     <= enter_rise;
            key_held   <= any_held;

            if (move_valid && move_ready) begin
                if (skid_valid && enable) begin
                    move_dir   <= skid_dir;
                    skid_valid <= 1'b0;
                end else begin
                    move_valid <= 1'b0;
                end
            end

            if (!enable) begin
                state      <= IDLE;
                timer      <= '0;
                skid_valid <= 1'b0;
            end else if (press) begin
                state  <= DELAY;
                timer  <= '0;
                active <= press_dir;
                // Later assignments override the transfer logic above.
                if (!move_valid || (move_ready && !skid_valid)) begin
                    move_valid <= 1'b1;
                    move_dir   <= press_dir;
                end else begin
                    skid_valid <= 1'b1;
                    skid_dir   <= press_dir;
                end
            end else if (active_lost) begin
                timer <= '0;
                if (any_held) begin
                    state  <= DELAY;
                    active <= held_dir;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: timer <= '0;
                    DELAY: begin
                        if (timer == DELAY_TC) begin
                            state <= REPEAT;
                            timer <= '0;
                            if (!move_valid) begin
                                move_valid <= 1'b1;
                                move_dir   <= active;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    REPEAT: begin
                        if (timer == REPEAT_TC) begin
                            timer <= '0;
                            if (!move_valid) begin
                                move_valid <= 1'b1;
                                move_dir   <= active;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_move_scheduler.sv
// Bench for ps2_move_scheduler: anchor-time move model checked every cycle,
// plus directed scenarios with hand-computed move timings.
module tb_ps2_move_scheduler;
    localparam int DLY = 8;
    localparam int RPT = 4;

    logic       clk, rst, enable, up, down, left, right, enter, move_ready;
    logic       move_valid, select, key_held;
    logic [1:0] move_dir;

    ps2_move_scheduler #(.DELAY_CYCLES(DLY), .REPEAT_CYCLES(RPT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .up(up), .down(down),
        .left(left), .right(right), .enter(enter), .move_ready(move_ready),
        .move_valid(move_valid), .move_dir(move_dir), .select(select),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sel_cnt = 0;
    int log_cyc[$];
    int log_dir[$];

    // Model state: a move slot, a skid slot, the active key and the cycle its timing anchors to.
    bit       m_valid, m_sel, m_kh, m_eprev, m_armed;
    bit [1:0] m_dir;
    bit [3:0] m_prev;
    int       m_skid, m_active, m_anchor, k;

    function automatic int lowest(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial forever @(posedge clk) cyc++;

    initial begin
        m_active = -1; m_skid = -1; m_anchor = 0; k = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_valid = 0; m_dir = 0; m_sel = 0; m_kh = 0; m_prev = 0;
                m_eprev = 0; m_armed = 0; m_skid = -1; m_active = -1;
            end else begin
                bit [3:0] lvl, rise;
                bit       old_valid, xfer, skid_full, rpt;
                int       pd;
                k++;
                lvl  = {right, left, down, up};
                rise = m_armed ? (lvl & ~m_prev) : 4'd0;
                m_sel = enter && !m_eprev && m_armed;
                m_kh  = (lvl != 0);
                old_valid = m_valid;
                xfer = m_valid && move_ready;
                pd = -1;
                rpt = 0;
                if (!enable) begin
                    m_active = -1;
                    m_skid = -1;
                end else if (rise != 0) begin
                    pd = lowest(rise);
                    m_active = pd;
                    m_anchor = k;
                end else if (m_active >= 0 && !lvl[m_active]) begin
                    if (lvl != 0) begin
                        m_active = lowest(lvl);
                        m_anchor = k;
                    end else begin
                        m_active = -1;
                    end
                end else if (m_active >= 0 && (k - m_anchor) >= DLY &&
                             ((k - m_anchor - DLY) % RPT) == 0) begin
                    rpt = 1;
                end
                skid_full = (m_skid >= 0);
                if (xfer) begin
                    if (skid_full) begin
                        m_dir = 2'(m_skid);
                        m_skid = -1;
                    end else begin
                        m_valid = 0;
                    end
                end
                if (pd >= 0) begin
                    if (!old_valid || (xfer && !skid_full)) begin
                        m_valid = 1;
                        m_dir = 2'(pd);
                    end else begin
                        m_skid = pd;
                    end
                end else if (rpt && !old_valid) begin
                    m_valid = 1;
                    m_dir = 2'(m_active);
                end
                m_prev = lvl;
                m_eprev = enter;
                m_armed = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("move_valid", int'(move_valid), int'(m_valid));
        if (m_valid) check("move_dir", int'(move_dir), int'(m_dir));
        check("select", int'(select), int'(m_sel));
        check("key_held", int'(key_held), int'(m_kh));
        if (!rst && move_valid && move_ready) begin
            log_cyc.push_back(cyc);
            log_dir.push_back(int'(move_dir));
        end
        if (select) sel_cnt++;
    end

    int c0, c1;
    int exp_off1[7] = '{1, 9, 13, 17, 21, 25, 29};

    initial begin
        rst = 1; enable = 1; up = 0; down = 0; left = 0; right = 0; enter = 0;
        move_ready = 1;
        cyc_wait(2);
        check("rst_valid", int'(move_valid), 0);
        check("rst_dir", int'(move_dir), 0);
        check("rst_select", int'(select), 0);
        check("rst_key_held", int'(key_held), 0);
        rst = 0;
        cyc_wait(3);

        // Single held key: immediate move, first repeat after DLY, then every RPT.
        log_cyc.delete(); log_dir.delete();
        c0 = cyc; up = 1;
        cyc_wait(30); up = 0;
        cyc_wait(12);
        check("t1_count", log_cyc.size(), 7);
        for (int i = 0; i < 7 && i < log_cyc.size(); i++) begin
            check("t1_cycle", log_cyc[i] - c0, exp_off1[i]);
            check("t1_dir", log_dir[i], 0);
        end

        // Simultaneous press resolves left; releasing left hands over to right with no immediate move.
        log_cyc.delete(); log_dir.delete();
        c0 = cyc; left = 1; right = 1;
        cyc_wait(3); left = 0;
        cyc_wait(10); right = 0;
        cyc_wait(6);
        check("t2_count", log_cyc.size(), 2);
        if (log_cyc.size() == 2) begin
            check("t2_first_cycle", log_cyc[0] - c0, 1);
            check("t2_first_dir", log_dir[0], 2);
            check("t2_handover_cycle", log_cyc[1] - c0, 12);
            check("t2_handover_dir", log_dir[1], 3);
        end

        // Stalled output: second press lands in the skid slot, repeats are dropped.
        log_cyc.delete(); log_dir.delete();
        move_ready = 0;
        c0 = cyc; down = 1;
        cyc_wait(3); up = 1;
        cyc_wait(14);
        check("t3_stall_valid", int'(move_valid), 1);
        check("t3_stall_dir", int'(move_dir), 1);
        move_ready = 1;
        cyc_wait(1); move_ready = 0;
        check("t3_skid_valid", int'(move_valid), 1);
        check("t3_skid_dir", int'(move_dir), 0);
        up = 0; down = 0;
        cyc_wait(3); move_ready = 1;
        cyc_wait(3);
        check("t3_count", log_cyc.size(), 2);
        if (log_cyc.size() == 2) begin
            check("t3_dir0", log_dir[0], 1);
            check("t3_dir1", log_dir[1], 0);
        end
        check("t3_drained", int'(move_valid), 0);

        // enter pulses: one select each, also while disabled.
        sel_cnt = 0;
        enter = 1; cyc_wait(5); enter = 0; cyc_wait(3);
        check("t4_select_en", sel_cnt, 1);
        enable = 0;
        enter = 1; cyc_wait(5); enter = 0; cyc_wait(3);
        check("t4_select_dis", sel_cnt, 2);
        enable = 1;
        cyc_wait(2);

        // enable low kills repeats; held key stays silent on re-enable until re-pressed.
        log_cyc.delete(); log_dir.delete();
        c0 = cyc; right = 1;
        cyc_wait(4); enable = 0;
        cyc_wait(15); enable = 1;
        cyc_wait(15);
        check("t5_count_held", log_cyc.size(), 1);
        right = 0;
        cyc_wait(2);
        c1 = cyc; right = 1;
        cyc_wait(2);
        check("t5_count_repress", log_cyc.size(), 2);
        if (log_cyc.size() == 2) begin
            check("t5_repress_cycle", log_cyc[1] - c1, 1);
            check("t5_repress_dir", log_dir[1], 3);
        end
        right = 0;
        cyc_wait(4);

        // Reset in REPEAT with the skid slot loaded; held keys stay silent afterwards.
        log_cyc.delete(); log_dir.delete();
        move_ready = 0;
        up = 1;
        cyc_wait(1); down = 1;
        cyc_wait(12);
        check("t6_pre_valid", int'(move_valid), 1);
        rst = 1;
        #1;
        check("t6_async_valid", int'(move_valid), 0);
        check("t6_async_dir", int'(move_dir), 0);
        check("t6_async_key_held", int'(key_held), 0);
        cyc_wait(2); rst = 0; move_ready = 1;
        cyc_wait(15);
        check("t6_count_held", log_cyc.size(), 0);
        down = 0;
        cyc_wait(2);
        c1 = cyc; down = 1;
        cyc_wait(2);
        check("t6_count_repress", log_cyc.size(), 1);
        if (log_cyc.size() == 1) begin
            check("t6_repress_cycle", log_cyc[0] - c1, 1);
            check("t6_repress_dir", log_dir[0], 1);
        end
        up = 0; down = 0;
        cyc_wait(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
